// File: rtl/imem_sram_rd.sv
// imem_sram_rd: fetch-side instruction reader over a 16-bit async SRAM, two halfword reads per word
module imem_sram_rd #(
   parameter int ADDR_W      = 18,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_inst,
   output logic              if_stall,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [15:0]       sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_bhe_n,
   output logic              sram_ble_n
);
   localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
   typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, BYPASS} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [ADDR_W-2:0] req_addr;
   logic [15:0] hi_reg;
   logic done, in_range, unused_ok;
   assign done = cnt == CW'(WAIT_STATES);
   assign in_range = if_addr[31:ADDR_W+1] == '0;
   assign unused_ok = &{1'b0, if_addr[1:0]};
   assign sram_we_n = 1'b1;
   assign sram_oe_n = sram_ce_n;
   assign sram_bhe_n = sram_ce_n;
   assign sram_ble_n = sram_ce_n;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = in_range ? RD_HI : BYPASS;
         RD_HI:   state_nxt = done ? RD_LO : RD_HI;
         RD_LO:   state_nxt = done ? IDLE : RD_LO;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         req_addr  <= '0;
         hi_reg    <= '0;
         if_inst   <= '0;
         if_stall  <= 1'b0;
         sram_addr <= '0;
         sram_ce_n <= 1'b1;
      end else begin
         state     <= state_nxt;
         if_stall  <= state_nxt != IDLE;
         sram_ce_n <= !(state_nxt == RD_HI || state_nxt == RD_LO);
         cnt       <= (state inside {RD_HI, RD_LO}) && !done ? cnt + 1'b1 : '0;
         if (state == IDLE) req_addr <= if_addr[ADDR_W:2];
         if (state == IDLE && in_range) sram_addr <= {if_addr[ADDR_W:2], 1'b0};
         if (state == RD_HI && done) begin
            hi_reg    <= sram_dq_in;
            sram_addr <= {req_addr, 1'b1};
         end
         if (state == RD_LO && done) if_inst <= {hi_reg, sram_dq_in};
         if (state == BYPASS) if_inst <= '0;
      end
   end
endmodule

// File: tb/tb_imem_sram_rd.sv
// tb_imem_sram_rd: two lanes (WAIT_STATES=1 and 0) driven by a fetch model and scored against a word-level reference
module tb_imem_sram_rd;
   localparam int AW = 18;
   typedef struct packed {
      logic [31:0]   inst;
      logic          ranged;
      logic [AW-1:0] hw;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst_q = 1'b0;
   int rst_gen = 0;
   int checks = 0;
   int failures = 0;
   logic [15:0] ovr [int];
   always #5 clk = ~clk;
   always @(posedge clk) rst_q <= rst;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [15:0] mem(logic [AW-1:0] a);
      return ovr.exists(int'(a)) ? ovr[int'(a)] : 16'((32'(a) * 7919 + (32'(a) >> 5)) ^ 32'hA5C3);
   endfunction
   function automatic exp_t model(logic [31:0] a);
      exp_t e;
      e.ranged = (a >> (AW + 1)) == 0;
      e.hw = AW'((a / 4) * 2);
      e.inst = e.ranged ? {mem(e.hw), mem(AW'(e.hw + 1))} : 32'h0;
      return e;
   endfunction
   function automatic logic [32:0] directed(int lane, int n);
      if (lane == 0)
         case (n)
            0: return {1'b1, 32'h0000_0000};
            1: return {1'b1, 32'h0000_0004};
            2: return {1'b1, 32'h0000_0008};
            3: return {1'b1, 32'h0000_007C};
            4: return {1'b1, 32'h0007_FFFC};
            5: return {1'b1, 32'h0008_0000};
            6: return {1'b1, 32'h0007_FFFF};
            default: return '0;
         endcase
      case (n)
         0: return {1'b1, 32'h0007_FFFC};
         1: return {1'b1, 32'hFFFF_FFFC};
         2: return {1'b1, 32'h0000_0000};
         default: return '0;
      endcase
   endfunction
   for (genvar k = 0; k < 2; k++) begin : g
      localparam int W = (k == 0) ? 1 : 0;
      logic [31:0] if_addr = '0;
      logic [31:0] if_inst;
      logic [15:0] dq = 16'hDEAD;
      logic [AW-1:0] sram_addr;
      logic if_stall, ce_n, oe_n, we_n, bhe_n, ble_n;
      exp_t exp_q [$];
      logic [AW-1:0] seen_q [$];
      logic [31:0] last_inst = '0;
      int stall_run = 0;
      int n_done = 0;
      int n_req = 0;
      imem_sram_rd #(.ADDR_W(AW), .WAIT_STATES(W)) dut (
         .clk(clk), .rst(rst), .if_addr(if_addr), .if_inst(if_inst), .if_stall(if_stall),
         .sram_addr(sram_addr), .sram_dq_in(dq), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
         .sram_we_n(we_n), .sram_bhe_n(bhe_n), .sram_ble_n(ble_n)
      );
      always @(negedge clk) begin
         exp_t e;
         logic [32:0] d;
         logic [31:0] a;
         int r;
         bit ok;
         if (!rst_q) begin
            exp_q.delete();
            seen_q.delete();
            stall_run = 0;
            last_inst = '0;
            n_req = 0;
            chk($sformatf("l%0d_rst_stall", k), 32'(if_stall), 32'd0);
            chk($sformatf("l%0d_rst_ce_n", k), 32'(ce_n), 32'd1);
            chk($sformatf("l%0d_rst_inst", k), if_inst, 32'd0);
            chk($sformatf("l%0d_rst_addr", k), 32'(sram_addr), 32'd0);
         end else begin
            chk($sformatf("l%0d_we_n", k), 32'(we_n), 32'd1);
            chk($sformatf("l%0d_oe_n", k), 32'(oe_n), 32'(ce_n));
            chk($sformatf("l%0d_bhe_n", k), 32'(bhe_n), 32'(ce_n));
            chk($sformatf("l%0d_ble_n", k), 32'(ble_n), 32'(ce_n));
            if (if_stall) begin
               stall_run++;
               chk($sformatf("l%0d_inst_hold", k), if_inst, last_inst);
               if (!ce_n) seen_q.push_back(sram_addr);
            end else if (stall_run > 0) begin
               chk($sformatf("l%0d_pending", k), 32'(exp_q.size()), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk($sformatf("l%0d_inst", k), if_inst, e.inst);
                  chk($sformatf("l%0d_stall_len", k), 32'(stall_run), e.ranged ? 32'(2 * (W + 1)) : 32'd1);
                  ok = seen_q.size() == (e.ranged ? 2 * (W + 1) : 0);
                  foreach (seen_q[i]) if (seen_q[i] != AW'(e.hw + (i > W ? 1 : 0))) ok = 0;
                  chk($sformatf("l%0d_sram_seq hw=%h", k, e.hw), 32'(ok), 32'd1);
                  last_inst = e.inst;
                  n_done++;
               end
               stall_run = 0;
               seen_q.delete();
            end
         end
         dq = (!ce_n && !oe_n) ? mem(sram_addr) : 16'hDEAD;
         if (rst && !if_stall) begin
            chk($sformatf("l%0d_idle_once", k), 32'(exp_q.size()), 32'd0);
            d = directed(k, n_req);
            a = $urandom;
            r = $urandom_range(0, 9);
            a = r < 6 ? (a & 32'h0007_FFFC) : (r < 8 ? (a | 32'h0008_0000) : (a & 32'h0007_FFFF));
            if (rst_gen == 1 && d[32]) a = d[31:0];
            if (rst_gen == 2 && n_req == 0) a = 32'hFFFF_FFFC;
            if_addr = a;
            exp_q.push_back(model(a));
            n_req++;
         end
      end
   end
   initial begin
      bit found, prev, cur;
      ovr[0] = 16'h2408;
      ovr[1] = 16'h0005;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      rst_gen = 1;
      repeat (150) @(posedge clk);
      found = 0;
      prev = 1;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         cur = !g[0].ce_n && g[0].sram_addr[0];
         found = cur && !prev;
         prev = cur;
      end
      chk("find_rd_lo", 32'(found), 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      rst_gen = 2;
      repeat (400) @(posedge clk);
      @(negedge clk);
      chk("l0_progress", 32'(g[0].n_done > 40), 32'd1);
      chk("l1_progress", 32'(g[1].n_done > 60), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_sram_rd.md
Name: imem_sram_rd

Overview:
- Instruction-memory responder for the fetch stage.
- Each time it is idle, it accepts the fetch stage's next-PC address.
- It reads the 32-bit instruction from an external asynchronous 16-bit SRAM as two halfword reads with programmable wait states.
- It returns the instruction to fetch and drives the fetch stage's PC-hold input (stall) while a read is in progress.

Parameters:
- ADDR_W, 18: SRAM halfword-address width; the SRAM byte space is 2^(ADDR_W+1) bytes.
- WAIT_STATES, 1: extra cycles per halfword access; each half-phase lasts WAIT_STATES+1 cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_addr  in  32  next-PC byte address from fetch (its PC mux output).
- if_inst  out  32  instruction for the address most recently read; goes to fetch's instruction input.
- if_stall  out  1  registered; 1 = fetch must hold its PC (connects to fetch PC write-enable hold).
- sram_addr  out  ADDR_W  SRAM halfword address.
- sram_dq_in  in  16  SRAM read data.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable; constant 1.
- sram_bhe_n, sram_ble_n  out  1  byte enables; 0 whenever sram_ce_n=0, else 1.

Behaviour:
- FSM states: IDLE, RD_HI, RD_LO, BYPASS.
- Reset (rst=0 at an edge): state=IDLE, if_inst=32'h0000_0000 (NOP), if_stall=0, sram_ce_n=sram_oe_n=1, sram_addr=0, wait counter=0, req_addr=0. Reset mid-read abandons the read with no write to if_inst.

IDLE:
- if_stall=0; SRAM deselected.
- At the next edge, capture req_addr<=if_addr and leave IDLE every time; there is no request-valid signal.
- If req_addr bits [31:ADDR_W+1] are all zero, go to RD_HI; otherwise go to BYPASS.
- Bits [1:0] of if_addr are ignored (word-aligned access).

RD_HI:
- if_stall=1; sram_ce_n=sram_oe_n=0.
- sram_addr={req_addr[ADDR_W:2],1'b0}, registered and stable for the whole phase.
- Wait counter runs 0..WAIT_STATES.
- At the edge where the counter equals WAIT_STATES, latch sram_dq_in into hi_reg, clear the counter, and go to RD_LO.

RD_LO:
- Same as RD_HI with sram_addr={req_addr[ADDR_W:2],1'b1}.
- At the terminal edge: if_inst<={hi_reg,sram_dq_in} (big-endian, even halfword = bits 31:16); if_stall<=0; go to IDLE.

BYPASS:
- Out-of-range address; no SRAM access.
- Lasts one cycle with if_stall=1; at its edge if_inst<=0 and the state goes to IDLE.

Timing and handshake:
- if_stall is a register and never depends combinationally on if_addr, so there is no loop through fetch's PC mux.
- While if_stall=1, fetch holds PC, so if_addr equals req_addr throughout the read.
- In-range latency, capture edge to if_stall fall: 2*(WAIT_STATES+1) cycles.
- Per-instruction period: 2*(WAIT_STATES+1)+1 cycles. With WAIT_STATES=1 the period is 5 cycles (stall high 4, low 1).
- if_inst changes only at the RD_LO or BYPASS terminal edge (or reset). It is held at all other times, including IDLE, so decode can sample it in the IDLE cycle.
- The SRAM address changes only on the edges entering RD_HI or RD_LO. oe_n/ce_n deassert on the edge entering IDLE or BYPASS.

Boundary conditions:
- WAIT_STATES=0: each half-phase is 1 cycle.
- Highest in-range word ({ADDR_W+1{1}} with [1:0]=0): normal read.
- Fetch reset vector 32'hFFFF_FFFC (out of range): BYPASS returns NOP.
- A redirect (branch stomp) changes if_addr only in IDLE and is captured at that edge. During a read, redirects are held off by fetch; this block does not cancel a read in progress.

Test Plan:
1. Reset, then if_addr=0x0, SRAM hw0=0x2408, hw1=0x0005, WAIT_STATES=1 -> sram_addr 0 for 2 cycles then 1 for 2 cycles; if_stall high 4 cycles; if_inst=0x24080005 when stall falls.
2. Sequential run 0x0,0x4,0x8 driven by a fetch model -> three instructions in order, 5-cycle period each; sram_addr 0,1,2,3,4,5.
3. if_addr=0xFFFF_FFFC after reset -> BYPASS: if_stall high 1 cycle, if_inst=0, sram_ce_n stays 1.
4. Redirect in IDLE from 0x8 to 0x7C -> next read uses sram_addr 0x3E then 0x3F; if_inst matches word 0x7C.
5. rst low during RD_LO -> next cycle IDLE, if_stall=0, sram_ce_n=1, if_inst=0; the aborted read never appears.
6. WAIT_STATES=0, last in-range word (0x7FFFC for ADDR_W=18) -> stall 2 cycles, sram_addr 0x3FFFE then 0x3FFFF, correct data returned.
